// File: rtl/ps2_rx_frame_register.sv
// rtl/ps2_rx_frame_register.sv - PS/2 receive frame capture register with parity, stop and timeout checks
module ps2_rx_frame_register #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 1,
    parameter int TIMEOUT    = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              sdata,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int              CW        = $clog2(DATA_W + 1);
    localparam int              TW        = $clog2(TIMEOUT);
    localparam logic            ODD       = (PARITY_ODD != 0);
    localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_W - 1);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              parity_ok;

    // Parity is judged over the data bits together with the received parity bit.
    assign parity_ok = ((^shreg_q) ^ par_q) == ODD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
            shreg_d = '0;
            par_d   = 1'b0;
        end else if (shift_en) begin
            timer_d = '0;
            case (state_q)
                IDLE: begin
                    if (!sdata) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {sdata, shreg_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = sdata;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (sdata) begin
                        if (parity_ok) begin
                            data_out_d   = shreg_q;
                            data_valid_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                    end else begin
                        frame_err_d  = 1'b1;
                        parity_err_d = !parity_ok;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A stalled frame is dropped once the timer has seen TIMEOUT idle busy cycles.
            if (timer_q == TIMER_MAX) begin
                state_d     = IDLE;
                timer_d     = '0;
                frame_err_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: doc/ps2_rx_frame_register.md
# ps2_rx_frame_register

Parametrised serial-capture register for PS/2 receive, the next generation of our N-bit parallel register. It accepts one already-synchronised data bit per `shift_en` strobe and assembles a start/data/parity/stop frame LSB-first. It checks parity and stop bit, aborts stalled frames on a timeout, and publishes the data byte in a held output register with a one-cycle valid pulse. It sits between the PS/2 clock-edge detector and the scan-code decoder.

## Interface
- `DATA_W`, 8: data bits per frame.
- `PARITY_ODD`, 1: 1 selects odd parity, 0 selects even parity, computed over data plus parity bit.
- `TIMEOUT`, 5000: number of consecutive busy cycles without `shift_en` before the frame is aborted. Must be ≥2.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `shift_en`  in  1  one-cycle strobe; `sdata` is a valid bit this cycle.
- `sdata`  in  1  serial data bit, already synchronised to `clk`.
- `clear`  in  1  synchronous abort of the frame in progress.
- `data_out`  out  DATA_W  last good frame's data, held until the next good frame.
- `data_valid`  out  1  one-cycle pulse; `data_out` was updated on this edge.
- `parity_err`  out  1  one-cycle pulse; the completed frame had bad parity.
- `frame_err`  out  1  one-cycle pulse; the stop bit was 0, or the frame timed out.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- States are IDLE, DATA, PARITY and STOP. Only cycles with `shift_en`=1 advance the state machine.
- **IDLE**
  - `shift_en` with `sdata`=0 (start bit): go to DATA, bit counter=0, timer=0.
  - `shift_en` with `sdata`=1: ignored, stay in IDLE.
- **DATA**
  - Each `shift_en` does `shreg <= {sdata, shreg[DATA_W-1:1]}`, so the first data bit lands in bit 0 after DATA_W shifts.
  - The counter increments on each shift; after the DATA_W-th bit, go to PARITY.
- **PARITY**
  - `shift_en`: latch `sdata` as the parity bit, go to STOP.
- **STOP**
  - `shift_en`: evaluate the frame and go to IDLE.
  - Parity is OK when `^{shreg, parity_bit}` equals `PARITY_ODD`.
  - Stop=1 and parity OK: `data_out <= shreg`, pulse `data_valid`.
  - Stop=1 and parity bad: pulse `parity_err`; `data_out` unchanged.
  - Stop=0: pulse `frame_err`; also pulse `parity_err` if parity is bad; `data_out` unchanged.
- **Timeout**
  - The timer clears in IDLE and on every `shift_en`, and increments on each busy cycle without `shift_en`.
  - If the timer is at TIMEOUT-1 and the cycle has no `shift_en`: go to IDLE and pulse `frame_err`.
- **Clear**
  - `clear`=1: go to IDLE; counter, timer, `shreg` and parity bit are zeroed.
  - No error or valid pulse is produced; `data_out` is held.
- Priority order: `reset` > `clear` > `shift_en` > timeout.
- Timer width is `$clog2(TIMEOUT)`. Counter width is `$clog2(DATA_W+1)`. Counter and timer never wrap.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. Internal state is IDLE, with `shreg`, counter and timer at 0.
- Reset is asynchronous: asserting it mid-frame clears everything immediately. Release is synchronous to `clk`.
- All outputs are registered.
- `data_valid` and the error flags are high for exactly one cycle, starting on the edge that samples the stop-bit `shift_en`. `data_out` changes on that same edge.
- `busy` rises on the edge that samples the start bit. It falls on the stop-bit edge, the timeout edge, or the `clear` edge.
- Latency from start bit to `data_valid` is DATA_W+3 accepted strobes.
- Back-to-back frames: a start bit strobed on the cycle right after the stop edge is accepted.
- `shift_en` on every cycle is legal; throughput is one bit per cycle.
- `shift_en` on the cycle the timer would expire resets the timer; no abort occurs.
- `clear` together with `shift_en` discards the bit.

## Test plan
- Good frame, defaults: strobe bits 0, 0,0,1,1,1,0,0,0, 0, 1 (start, 0x1C LSB-first, parity 0, stop) → `data_out`=0x1C, `data_valid` high for 1 cycle on the 11th strobe edge, both error flags 0, `busy` 0 afterwards.
- Parity error: same frame with parity bit 1 → `parity_err` 1-cycle pulse, `data_valid` stays 0, `data_out` keeps its previous value. A following good 0xF0 frame (parity 1) → `data_out`=0xF0.
- Framing error: 0x1C frame with stop bit 0 → `frame_err` pulse, no `data_valid`. Idle strobes with `sdata`=1 before the next frame leave `busy`=0.
- Timeout with `TIMEOUT`=16: start bit plus 3 data bits, then no strobes → `frame_err` pulses on the 16th idle cycle and `busy` drops. A strobe on cycle 15 instead resets the timer and no abort occurs.
- Clear and reset: assert `clear` after 5 data bits → `busy` 0 next cycle, no pulses, `data_out` held. Drop `reset` mid-frame → all outputs 0 immediately. A full good frame after release is received correctly.
- Parameter sweep with `DATA_W`=9, `PARITY_ODD`=0, on data 0x1A5 (5 ones, parity bit 1) → `data_valid`, `data_out`=0x1A5; back-to-back with a second frame strobed every cycle also succeeds.
